fetch_sequencer: RTL and testbench

//  Fetch-stage controller for the instruction memory. Drives the PC into the combinational

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared fetch-stage constants and state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FS_RUN   = 2'd0;
  localparam fetch_state_t FS_DRAIN = 2'd1;
  localparam fetch_state_t FS_SHOW  = 2'd2;
  localparam fetch_state_t FS_HALT  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer : PC / IF-ID slot controller with end-of-program drain+halt
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter int          TAM          = 4,
  parameter int          DRAIN_CYCLES = 6,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        mostrar_o,
  output logic        halted_o,
  output logic        oob_o
);

  localparam int           CW     = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DRAIN_CYCLES - 1);

  fetch_state_t  r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic          r_valid;
  logic          r_oob;
  logic [CW-1:0] r_cnt;

  logic [31:0]   w_pc_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_oob;
  logic          w_end;
  logic          w_unused_pc_lsb;

  assign w_pc_next       = r_pc + PC_STEP;
  assign w_cnt_next      = r_cnt + CW'(1);
  assign w_oob           = r_pc[31:2] > 30'(TAM);
  assign w_end           = (instr_i == 32'h0) || w_oob;
  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FS_RUN;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_oob   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == FS_HALT) begin
      r_valid <= 1'b0;
    end else if (redirect_i) begin
      // A redirect is older than any end detection it races with, so it wins.
      r_state <= FS_RUN;
      r_pc    <= {redirect_pc_i[31:2], 2'b00};
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (!stall_i) begin
      r_pc <= w_pc_next;
      case (r_state)
        FS_RUN: begin
          if (w_end) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            r_cnt   <= CW'(1);
            r_oob   <= r_oob | w_oob;
            r_state <= (C_LAST == CW'(1)) ? FS_SHOW : FS_DRAIN;
          end else begin
            r_instr <= instr_i;
            r_valid <= 1'b1;
          end
        end
        FS_DRAIN: begin
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
          r_cnt   <= w_cnt_next;
          if (w_cnt_next == C_LAST) begin
            r_state <= FS_SHOW;
          end
        end
        FS_SHOW: begin
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
          r_state <= FS_HALT;
        end
        default: begin
          r_state <= FS_HALT;
        end
      endcase
    end
  end

  assign pc_o          = r_pc;
  assign instr_o       = r_instr;
  assign instr_valid_o = r_valid;
  assign oob_o         = r_oob;
  assign mostrar_o     = (r_state == FS_SHOW);
  assign halted_o      = (r_state == FS_HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer : directed bench for two fetch_sequencer instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int          DC  = 6;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redir;
  logic [31:0] rpc;

  logic [31:0] pc7, ins7, w7, pc4, ins4, w4;
  logic        v7, ms7, h7, o7, v4, ms4, h4, o4;

  int n_vec;
  int n_miss;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          valid;
    bit          ended;
    logic [31:0] endpc;
    bit          halted;
    bit          oob;
  } mdl_t;

  mdl_t m7, m4;

  // Program ROMs: program A ends on a zero word at index 3, program B is all nonzero.
  function automatic logic [31:0] romw(input bit prog_b, input logic [31:0] pc);
    logic [29:0] idx;
    idx = pc[31:2];
    if (idx >= 30'd16) return 32'h0BAD0013;
    if (prog_b) return 32'h01000000 + {2'b00, idx} + 32'd1;
    case (idx)
      30'd0:   return 32'h00100093;
      30'd1:   return 32'h00200113;
      30'd2:   return 32'h00308193;
      30'd3:   return 32'h00000000;
      default: return 32'h00A00513;
    endcase
  endfunction

  assign w7 = romw(1'b0, pc7);
  assign w4 = romw(1'b1, pc4);

  fetch_sequencer #(.TAM(7), .DRAIN_CYCLES(DC), .RESET_PC(32'h0)) dut7 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redir),
    .redirect_pc_i(rpc), .instr_i(w7), .pc_o(pc7), .instr_o(ins7),
    .instr_valid_o(v7), .mostrar_o(ms7), .halted_o(h7), .oob_o(o7));

  fetch_sequencer #(.TAM(4), .DRAIN_CYCLES(DC), .RESET_PC(32'h0)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redir),
    .redirect_pc_i(rpc), .instr_i(w4), .pc_o(pc4), .instr_o(ins4),
    .instr_valid_o(v4), .mostrar_o(ms4), .halted_o(h4), .oob_o(o4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t mreset();
    mdl_t m;
    m.pc = 32'h0; m.instr = NOP; m.valid = 0; m.ended = 0;
    m.endpc = 32'h0; m.halted = 0; m.oob = 0;
    return m;
  endfunction

  // Once the end PC P is known, SHOW is simply "pc == P + 4*(DC-1)" and halt follows.
  function automatic mdl_t mstep(input mdl_t mi, input int tam, input logic [31:0] word,
                                 input bit st, input bit rd, input logic [31:0] tgt);
    mdl_t m;
    m = mi;
    if (m.halted) return m;
    if (rd) begin
      m.pc = tgt & ~32'h3; m.instr = NOP; m.valid = 0; m.ended = 0;
      return m;
    end
    if (st) return m;
    if (m.ended) begin
      if (m.pc == m.endpc + 4 * (DC - 1)) m.halted = 1;
      m.instr = NOP; m.valid = 0;
    end else if (word == 0 || (m.pc >> 2) > tam) begin
      m.ended = 1; m.endpc = m.pc;
      if ((m.pc >> 2) > tam) m.oob = 1;
      m.instr = NOP; m.valid = 0;
    end else begin
      m.instr = word; m.valid = 1;
    end
    m.pc = m.pc + 4;
    return m;
  endfunction

  function automatic bit mshow(input mdl_t m);
    return m.ended && !m.halted && (m.pc == m.endpc + 4 * (DC - 1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m7 = mreset();
      m4 = mreset();
    end else begin
      m7 = mstep(m7, 7, romw(1'b0, m7.pc), stall, redir, rpc);
      m4 = mstep(m4, 4, romw(1'b1, m4.pc), stall, redir, rpc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("m7.pc", pc7, m7.pc);
    chk("m7.instr", ins7, m7.instr);
    chk("m7.valid", {31'b0, v7}, {31'b0, m7.valid});
    chk("m7.mostrar", {31'b0, ms7}, {31'b0, mshow(m7)});
    chk("m7.halted", {31'b0, h7}, {31'b0, m7.halted});
    chk("m7.oob", {31'b0, o7}, {31'b0, m7.oob});
    chk("m4.pc", pc4, m4.pc);
    chk("m4.instr", ins4, m4.instr);
    chk("m4.valid", {31'b0, v4}, {31'b0, m4.valid});
    chk("m4.mostrar", {31'b0, ms4}, {31'b0, mshow(m4)});
    chk("m4.halted", {31'b0, h4}, {31'b0, m4.halted});
    chk("m4.oob", {31'b0, o4}, {31'b0, m4.oob});
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic wait_pc7(input logic [31:0] p, input string name);
    for (int i = 0; i < 100; i++) begin
      if (pc7 == p) return;
      step();
    end
    chk({name, ".timeout"}, pc7, p);
  endtask

  int ms_cyc2, ms_cyc3, ms_cnt, cyc;
  logic [31:0] ms_pc4;

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
    step(); step();
    chk("rst.pc", pc7, 32'h0);
    chk("rst.instr", ins7, NOP);
    chk("rst.flags", {28'b0, v7, ms7, h7, o7}, 32'h0);
    rst_n = 1'b1;

    // Program A normal run alongside program B out-of-bounds run
    ms_cyc2 = -1; ms_cnt = 0; ms_pc4 = 32'hFFFFFFFF;
    for (int c = 0; c < 40; c++) begin
      if (ms7) begin
        ms_cnt++;
        if (ms_cyc2 < 0) ms_cyc2 = c;
        chk("t2.show_pc", pc7, 32'd32);
      end
      if (ms4) ms_pc4 = pc4;
      if (pc4 == 32'd24) chk("t6.oob_at_drain", {31'b0, o4}, 32'd1);
      step();
    end
    chk("t2.show_cycles", ms_cnt, 32'd1);
    chk("t2.show_when", ms_cyc2, 32'd8);
    chk("t2.halt_pc", pc7, 32'd36);
    chk("t2.halted", {31'b0, h7}, 32'd1);
    chk("t2.no_oob", {31'b0, o7}, 32'd0);
    chk("t6.show_pc", ms_pc4, 32'd40);
    chk("t6.halt_pc", pc4, 32'd44);
    chk("t6.oob", {31'b0, o4}, 32'd1);

    // Halted ignores redirect and stall
    redir = 1'b1; rpc = 32'h8; stall = 1'b1;
    step();
    redir = 1'b0; stall = 1'b0;
    chk("halt.ignore_redir", pc7, 32'd36);
    step();

    // Stall for 3 edges while pc=20
    do_reset();
    cyc = 0; ms_cyc3 = -1;
    for (int c = 0; c < 40; c++) begin
      if (ms7 && ms_cyc3 < 0) ms_cyc3 = cyc;
      if (pc7 == 32'd20 && c < 8) begin
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
          step(); cyc++;
          chk("t3.hold", pc7, 32'd20);
        end
        stall = 1'b0;
      end
      step(); cyc++;
    end
    chk("t3.show_when", ms_cyc3, 32'd11);

    // Redirect during drain
    do_reset();
    wait_pc7(32'd24, "t4");
    redir = 1'b1; rpc = 32'h4;
    step();
    redir = 1'b0;
    chk("t4.pc", pc7, 32'd4);
    chk("t4.instr", ins7, NOP);
    chk("t4.valid", {31'b0, v7}, 32'd0);
    chk("t4.mostrar", {31'b0, ms7}, 32'd0);
    for (int c = 0; c < 20; c++) step();

    // Stall and redirect together; low target bits dropped
    do_reset();
    wait_pc7(32'd4, "t5");
    stall = 1'b1; redir = 1'b1; rpc = 32'h12;
    step();
    stall = 1'b0; redir = 1'b0;
    chk("t5.pc", pc7, 32'h10);
    for (int c = 0; c < 5; c++) step();

    // Asynchronous reset mid-run and mid-SHOW
    do_reset();
    wait_pc7(32'd8, "t1");
    rst_n = 1'b0;
    #1;
    chk("t1.pc", pc7, 32'h0);
    chk("t1.flags", {29'b0, v7, ms7, h7}, 32'h0);
    step();
    rst_n = 1'b1;
    wait_pc7(32'd32, "t1b");
    chk("t1b.in_show", {31'b0, ms7}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1b.no_strobe", {31'b0, ms7}, 32'd0);
    chk("t1b.pc", pc7, 32'h0);
    step();
    rst_n = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
